// File: rtl/pmod_kypd_scan.sv
// pmod_kypd_scan: scans a Pmod KYPD 4x4 keypad one column at a time and
// reports one debounced key as a hex code. A press gives a single strobe.
// Optional feature macro: KYPD_RELEASE_STB_EN (when defined, an accepted
// release also pulses KEY_STB).
module pmod_kypd_scan #(
  parameter int COL_DIV = 12000,
  parameter int DEB_CNT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] COL,
  input  logic [3:0] ROW,
  output logic [3:0] KEY_CODE,
  output logic       KEY_DOWN,
  output logic       KEY_STB,
  output logic [7:0] KEY_BYTE
);

  localparam int DW = $clog2(COL_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DIV - 1);
  localparam logic [3:0] DEB_TGT = 4'(DEB_CNT);

  // Index of the lowest pressed key in the map (bit i = c*4+r); 0 if none.
  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Keypad legend for map index c*4+r.
  function automatic logic [3:0] key_hex(input logic [3:0] idx);
    logic [3:0] h;
    case (idx)
      4'd0:    h = 4'h1;
      4'd1:    h = 4'h4;
      4'd2:    h = 4'h7;
      4'd3:    h = 4'h0;
      4'd4:    h = 4'h2;
      4'd5:    h = 4'h5;
      4'd6:    h = 4'h8;
      4'd7:    h = 4'hF;
      4'd8:    h = 4'h3;
      4'd9:    h = 4'h6;
      4'd10:   h = 4'h9;
      4'd11:   h = 4'hE;
      4'd12:   h = 4'hA;
      4'd13:   h = 4'hB;
      4'd14:   h = 4'hC;
      4'd15:   h = 4'hD;
      default: h = 4'h0;
    endcase
    return h;
  endfunction

  logic [3:0]    rs_meta_r, rs_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    col_r, col_nxt_s;
  logic [3:0]    col_drv_r, col_drv_s;
  logic [15:0]   map_r, map_full_s;
  logic          sample_s, scan_end_s, found_s, accept_s;
  logic [4:0]    cand_s, prev_cand_r, stable_r;
  logic [3:0]    deb_cnt_r, cnt_nxt_s;
  logic [3:0]    key_code_r;
  logic          key_down_r, key_stb_r;

  assign sample_s   = (dwell_r == DWELL_LAST);
  assign scan_end_s = sample_s && (col_r == 2'd3);

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rs_meta_r <= 4'b1111;
      rs_r      <= 4'b1111;
    end else begin
      rs_meta_r <= ROW;
      rs_r      <= rs_meta_r;
    end
  end

  // Dwell counter: time spent driving the current column.
  always_ff @(posedge CLK) begin
    if (RST)           dwell_r <= '0;
    else if (sample_s) dwell_r <= '0;
    else               dwell_r <= dwell_r + 1'b1;
  end

  // Column FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) col_r <= 2'd0;
    else     col_r <= col_nxt_s;
  end

  // Column FSM next state: advance after the last dwell cycle.
  always_comb begin
    col_nxt_s = col_r;
    if (sample_s) col_nxt_s = col_r + 2'd1;
    else          col_nxt_s = col_r;
  end

  // Column FSM output decode: one-hot-low drive for the upcoming column.
  always_comb begin
    col_drv_s = 4'b1111;
    case (col_nxt_s)
      2'd0:    col_drv_s = 4'b1110;
      2'd1:    col_drv_s = 4'b1101;
      2'd2:    col_drv_s = 4'b1011;
      2'd3:    col_drv_s = 4'b0111;
      default: col_drv_s = 4'b1110;
    endcase
  end

  // Registered column drive so the pins never glitch during decode.
  always_ff @(posedge CLK) begin
    if (RST) col_drv_r <= 4'b1110;
    else     col_drv_r <= col_drv_s;
  end

  // Scan map: capture pressed rows of the current column at its last cycle.
  always_ff @(posedge CLK) begin
    if (RST)           map_r <= 16'h0000;
    else if (sample_s) map_r[{col_r, 2'b00} +: 4] <= ~rs_r;
  end

  // Column 3 is still being sampled at scan end, so splice it in directly.
  assign map_full_s = {~rs_r, map_r[11:0]};
  assign found_s    = |map_full_s;
  assign cand_s     = found_s ? {1'b1, lowest_idx(map_full_s)} : 5'b0_0000;

  // Debounce count for this scan's candidate.
  always_comb begin
    cnt_nxt_s = 4'd1;
    if (cand_s == prev_cand_r) begin
      if (deb_cnt_r == 4'd15) cnt_nxt_s = 4'd15;
      else                    cnt_nxt_s = deb_cnt_r + 4'd1;
    end else begin
      cnt_nxt_s = 4'd1;
    end
  end

  assign accept_s = scan_end_s && (cnt_nxt_s >= DEB_TGT) && (cand_s != stable_r);

  // Debounce history and accepted (stable) keypad state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_cand_r <= 5'b0_0000;
      deb_cnt_r   <= 4'd0;
      stable_r    <= 5'b0_0000;
    end else if (scan_end_s) begin
      prev_cand_r <= cand_s;
      deb_cnt_r   <= cnt_nxt_s;
      if (accept_s) stable_r <= cand_s;
    end
  end

  // Key outputs: update code/down and pulse the strobe on acceptance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_code_r <= 4'h0;
      key_down_r <= 1'b0;
      key_stb_r  <= 1'b0;
    end else begin
      key_stb_r <= 1'b0;
      if (accept_s) begin
        if (found_s) begin
          key_code_r <= key_hex(cand_s[3:0]);
          key_down_r <= 1'b1;
          key_stb_r  <= 1'b1;
        end else begin
          key_down_r <= 1'b0;
`ifdef KYPD_RELEASE_STB_EN
          key_code_r <= key_hex(stable_r[3:0]);
          key_stb_r  <= 1'b1;
`else
          key_code_r <= key_code_r;
`endif
        end
      end
    end
  end

  assign COL      = col_drv_r;
  assign KEY_CODE = key_code_r;
  assign KEY_DOWN = key_down_r;
  assign KEY_STB  = key_stb_r;
  assign KEY_BYTE = {key_down_r, 3'b000, key_code_r};

endmodule
